clk_rate_monitor: RTL and testbench

- Receive-side counterpart to the project's clock dividers: takes a divided clock (e.g. the 25 MHz pixel clock derived from 100 MHz) back into the fast domain.
- Produces a one-cycle rising-edge strobe usable as a clock enable.
- Measures the divided clock's period in fast-clock cycles and reports lock, stuck and rate faults.
- Sits beside each divider instance so the VGA and input logic can run on `in_clk` with enables instead of derived clocks.

---
 rtl/clk_rate_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_clk_rate_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_monitor.sv
// -----------------------------------------------------------------------------
// clk_rate_monitor
//   Brings a divided clock (div_clk) back into the fast in_clk domain as a
//   one-cycle rising-edge enable. It also measures the divided clock's period
//   in in_clk cycles and reports lock, stuck and rate faults. This lets
//   downstream logic run on in_clk with enables instead of derived clocks.
//
// Parameters
//   CNT_W       width of the period counter / period output
//   EXP_PERIOD  expected div_clk period in in_clk cycles
//   TOL         allowed absolute deviation from EXP_PERIOD
//   LOCK_COUNT  consecutive good periods needed to assert locked (1..15)
//   TIMEOUT     cycles without an edge before stuck is flagged
//
// Ports
//   in_clk        in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   monitor enable, low = synchronous clear of all state
//   div_clk       in   divided clock under observation (asynchronous)
//   edge_pulse    out  one-cycle strobe per div_clk rising edge
//   period        out  last measured period (saturates at 2^CNT_W-1)
//   period_valid  out  one-cycle strobe when period updates
//   locked        out  rate confirmed within tolerance
//   stuck         out  no edge for TIMEOUT cycles
//   rate_err      out  one-cycle strobe on an out-of-tolerance period
// -----------------------------------------------------------------------------
module clk_rate_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_clk,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck,
  output logic             rate_err
);

  typedef enum logic {
    ST_ACQ    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Tolerance window; a negative lower bound clamps to zero.
  localparam int               LO_INT  = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [CNT_W-1:0] LO_B    = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0] HI_B    = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LOCK_M1 = 4'(LOCK_COUNT - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             first_seen_q, first_seen_d;
  state_e           state_q, state_d;
  logic             edge_pulse_q, edge_pulse_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;
  logic             rate_err_q, rate_err_d;

  logic             edge_s;
  logic             good_s;
  logic             cnt_sat_s;

  // s1/s2 form the metastability synchronizer; s3 only delays s2 for edge detect.
  assign edge_s    = s2_q & ~s3_q;
  // The count captured at an edge is the period that just ended.
  assign good_s    = (cnt_q >= LO_B) && (cnt_q <= HI_B);
  assign cnt_sat_s = (cnt_q == CNT_MAX);

  // Next-state logic: synchronizer, period counter, capture, lock FSM, timeout.
  always_comb begin
    s1_d           = div_clk;
    s2_d           = s1_q;
    s3_d           = s2_q;
    edge_pulse_d   = edge_s;
    cnt_d          = cnt_q;
    good_cnt_d     = good_cnt_q;
    first_seen_d   = first_seen_q;
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    stuck_d        = stuck_q;
    rate_err_d     = 1'b0;

    if (!en) begin
      s1_d         = 1'b0;
      s2_d         = 1'b0;
      s3_d         = 1'b0;
      edge_pulse_d = 1'b0;
      cnt_d        = {CNT_W{1'b0}};
      good_cnt_d   = 4'd0;
      first_seen_d = 1'b0;
      state_d      = ST_ACQ;
      period_d     = {CNT_W{1'b0}};
      locked_d     = 1'b0;
      stuck_d      = 1'b0;
    end else if (edge_s) begin
      // An edge always wins over a timeout in the same cycle.
      cnt_d   = CNT_ONE;
      stuck_d = 1'b0;
      if (first_seen_q) begin
        period_d       = cnt_q;
        period_valid_d = 1'b1;
        if (good_s) begin
          case (state_q)
            ST_ACQ: begin
              if (good_cnt_q == LOCK_M1) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                good_cnt_d = 4'd0;
              end else begin
                good_cnt_d = good_cnt_q + 4'd1;
              end
            end
            ST_LOCKED: begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
            default: begin
              state_d    = ST_ACQ;
              locked_d   = 1'b0;
              good_cnt_d = 4'd0;
            end
          endcase
        end else begin
          state_d    = ST_ACQ;
          locked_d   = 1'b0;
          good_cnt_d = 4'd0;
          rate_err_d = 1'b1;
        end
      end else begin
        // First edge after reset/enable/timeout: the partial period is discarded.
        first_seen_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_sat_s ? cnt_q : (cnt_q + CNT_ONE);
      // Fires once, on the cycle the counter steps onto TIMEOUT.
      if (cnt_q == TO_M1) begin
        stuck_d      = 1'b1;
        state_d      = ST_ACQ;
        locked_d     = 1'b0;
        good_cnt_d   = 4'd0;
        first_seen_d = 1'b0;
      end else begin
        stuck_d = stuck_q;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      good_cnt_q     <= 4'd0;
      first_seen_q   <= 1'b0;
      state_q        <= ST_ACQ;
      edge_pulse_q   <= 1'b0;
      period_q       <= {CNT_W{1'b0}};
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
      rate_err_q     <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      first_seen_q   <= first_seen_d;
      state_q        <= state_d;
      edge_pulse_q   <= edge_pulse_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
      rate_err_q     <= rate_err_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;
  assign rate_err     = rate_err_q;

endmodule

// File: tb/tb_clk_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_rate_monitor
//   Three monitor instances (default, TOL=1, CNT_W=4/TIMEOUT=15) see the same
//   div_clk/en/rst_n; one is selected for checking at a time. Each driven
//   div_clk rise pushes its expected edge_pulse record onto a queue; a negedge
//   monitor pops it when edge_pulse appears and compares every output.
// -----------------------------------------------------------------------------
module tb_clk_rate_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic div_clk;

  logic       ep0, pv0, lk0, st0, re0;
  logic [7:0] per0;
  logic       ep1, pv1, lk1, st1, re1;
  logic [7:0] per1;
  logic       ep2, pv2, lk2, st2, re2;
  logic [3:0] per2;

  always #5 clk = ~clk;

  clk_rate_monitor dut0 (
    .in_clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
    .edge_pulse(ep0), .period(per0), .period_valid(pv0),
    .locked(lk0), .stuck(st0), .rate_err(re0)
  );

  clk_rate_monitor #(.TOL(1)) dut1 (
    .in_clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
    .edge_pulse(ep1), .period(per1), .period_valid(pv1),
    .locked(lk1), .stuck(st1), .rate_err(re1)
  );

  clk_rate_monitor #(.CNT_W(4), .TIMEOUT(15)) dut2 (
    .in_clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
    .edge_pulse(ep2), .period(per2), .period_valid(pv2),
    .locked(lk2), .stuck(st2), .rate_err(re2)
  );

  int         sel = 0;
  logic       mon_ep, mon_pv, mon_lk, mon_st, mon_re;
  logic [7:0] mon_per;

  always_comb begin
    case (sel)
      0:       begin mon_ep = ep0; mon_pv = pv0; mon_lk = lk0; mon_st = st0; mon_re = re0; mon_per = per0; end
      1:       begin mon_ep = ep1; mon_pv = pv1; mon_lk = lk1; mon_st = st1; mon_re = re1; mon_per = per1; end
      default: begin mon_ep = ep2; mon_pv = pv2; mon_lk = lk2; mon_st = st2; mon_re = re2; mon_per = {4'b0000, per2}; end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int after;   // cycles from this rise to the next rise
    bit v;       // expected period_valid at this edge
    int per;     // expected period
    bit err;     // expected rate_err
    bit lk;      // expected locked
  } vec_t;

  typedef struct {
    int cyc;
    bit v;
    int per;
    bit err;
    bit lk;
  } exp_t;

  vec_t vt[27];
  exp_t q[$];

  int n_vec  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  int last_ep_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic set_vec(input int i, input int a, input bit v, input int p, input bit e, input bit l);
    vt[i].after = a;
    vt[i].v     = v;
    vt[i].per   = p;
    vt[i].err   = e;
    vt[i].lk    = l;
  endtask

  // Scoreboard monitor: compare on edge_pulse, flag stray or missing strobes.
  exp_t e_mon;
  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_ep === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_edge_pulse: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_mon = q.pop_front();
          chk("edge_pulse_cycle", cyc, e_mon.cyc);
          chk("period_valid", mon_pv, e_mon.v);
          if (e_mon.v) chk("period", mon_per, e_mon.per);
          chk("rate_err", mon_re, e_mon.err);
          chk("locked", mon_lk, e_mon.lk);
          chk("stuck_at_edge", mon_st, 0);
          last_ep_cyc = cyc;
        end
      end else begin
        chk("stray_strobe", {mon_pv, mon_re}, 0);
        if (q.size() > 0 && cyc > q[0].cyc) begin
          n_vec++;
          n_fail++;
          $display("FAIL missing_edge_pulse: got none expected at cycle %0d", q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic run_seq(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_t e;
      e.cyc = cyc + 3;
      e.v   = vt[i].v;
      e.per = vt[i].per;
      e.err = vt[i].err;
      e.lk  = vt[i].lk;
      div_clk = 1'b1;
      q.push_back(e);
      repeat (vt[i].after / 2) @(negedge clk);
      div_clk = 1'b0;
      repeat (vt[i].after - vt[i].after / 2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_edge_pulse", mon_ep, 0);
    chk("rst_period", mon_per, 0);
    chk("rst_period_valid", mon_pv, 0);
    chk("rst_locked", mon_lk, 0);
    chk("rst_stuck", mon_st, 0);
    chk("rst_rate_err", mon_re, 0);
    #1;
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int c0;
    rst_n   = 1'b0;
    en      = 1'b1;
    div_clk = 1'b0;

    // Default DUT: clean lock (0..5), stretched period while locked (6..10).
    set_vec( 0, 4, 1'b0, 0, 1'b0, 1'b0);
    set_vec( 1, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec( 2, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec( 3, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec( 4, 4, 1'b1, 4, 1'b0, 1'b1);
    set_vec( 5, 6, 1'b1, 4, 1'b0, 1'b1);
    set_vec( 6, 4, 1'b1, 6, 1'b1, 1'b0);
    set_vec( 7, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec( 8, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec( 9, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec(10, 4, 1'b1, 4, 1'b0, 1'b1);
    // TOL=1 DUT: periods 3,5,4,4 all good.
    set_vec(11, 3, 1'b0, 0, 1'b0, 1'b0);
    set_vec(12, 5, 1'b1, 3, 1'b0, 1'b0);
    set_vec(13, 4, 1'b1, 5, 1'b0, 1'b0);
    set_vec(14, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec(15, 4, 1'b1, 4, 1'b0, 1'b1);
    // Same stimulus on the TOL=0 DUT: 3 and 5 are errors, lock needs four 4s.
    set_vec(16, 3, 1'b0, 0, 1'b0, 1'b0);
    set_vec(17, 5, 1'b1, 3, 1'b1, 1'b0);
    set_vec(18, 4, 1'b1, 5, 1'b1, 1'b0);
    set_vec(19, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec(20, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec(21, 4, 1'b1, 4, 1'b0, 1'b0);
    set_vec(22, 4, 1'b1, 4, 1'b0, 1'b1);
    // CNT_W=4/TIMEOUT=15 DUT: 20-cycle gaps time out, so no period reported.
    set_vec(23, 20, 1'b0, 0, 1'b0, 1'b0);
    set_vec(24, 20, 1'b0, 0, 1'b0, 1'b0);
    set_vec(25, 4,  1'b0, 0, 1'b0, 1'b0);
    set_vec(26, 4,  1'b1, 4, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Clean lock, then a single 6-cycle period and re-lock.
    sel = 0;
    do_reset();
    repeat (3) @(negedge clk);
    run_seq(0, 10);

    // Stuck clock: hold div_clk low after lock.
    guard = 0;
    while (cyc != last_ep_cyc + 62 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("stuck_wait_in_budget", (guard < 200), 1);
    chk("stuck_before_timeout", mon_st, 0);
    chk("locked_before_timeout", mon_lk, 1);
    @(negedge clk);
    chk("stuck_at_timeout", mon_st, 1);
    chk("locked_at_timeout", mon_lk, 0);
    repeat (5) @(negedge clk);
    chk("stuck_held", mon_st, 1);

    // Resume: first edge clears stuck without a period, then re-lock.
    run_seq(0, 4);

    // Async reset while locked, then re-acquire after 5 edges.
    chk("locked_pre_reset", mon_lk, 1);
    do_reset();
    repeat (2) @(negedge clk);
    run_seq(0, 4);

    // Tolerance window with TOL=1.
    sel = 1;
    do_reset();
    repeat (2) @(negedge clk);
    run_seq(11, 15);

    // Same stimulus with TOL=0.
    sel = 0;
    do_reset();
    repeat (2) @(negedge clk);
    run_seq(16, 22);

    // en gating and saturation on the narrow-counter DUT.
    sel = 2;
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      div_clk = ((k % 4) < 2);
      @(negedge clk);
      chk("en_low_edge_pulse", mon_ep, 0);
      chk("en_low_period_valid", mon_pv, 0);
    end
    en      = 1'b1;
    div_clk = 1'b0;
    c0      = cyc;
    repeat (14) @(negedge clk);
    chk("narrow_stuck_before_to", mon_st, 0);
    @(negedge clk);
    chk("narrow_cycles_to_timeout", cyc - c0, 15);
    chk("narrow_stuck_at_to", mon_st, 1);
    run_seq(23, 26);

    repeat (8) @(negedge clk);
    chk("pending_edges", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
